// File: rtl/sdram_rd_capture.sv
// sdram_rd_capture: counts out read latency, then captures one burst into a show-ahead FIFO.
// Optional feature macro RDCAP_LAST_TAG_EN adds a per-word end-of-burst tag on rd_last.
module sdram_rd_capture #(
  parameter int DSIZE = 16,
  parameter int LAT   = 4,
  parameter int DEPTH = 16,
  parameter int BL_W  = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_start,
  input  logic [BL_W-1:0]  rd_len,
  output logic             rd_rej,
  output logic             rd_busy,
  input  logic [DSIZE-1:0] dataout,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
`ifdef RDCAP_LAST_TAG_EN
  output logic             rd_last,
`endif
  output logic [AW:0]      fifo_level
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT
  } state_t;

  state_t           state_q;
  logic [3:0]       lat_q;
  logic [BL_W-1:0]  cnt_q;
  logic             rej_q;

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      lvl_q;

  logic [31:0]      free_w;
  logic             space_ok;
  logic             accept;
  logic             push;
  logic             pop;

  // Space is reserved here, so the burst itself never needs a full check.
  assign free_w   = 32'(DEPTH) - 32'(lvl_q);
  assign space_ok = free_w >= 32'(rd_len);
  assign accept   = rd_start && (state_q == IDLE)
                    && (rd_len != '0) && space_ok;
  assign push     = (state_q == CAPT);
  assign pop      = rd_valid && rd_ready;

  assign rd_busy    = (state_q != IDLE);
  assign rd_rej     = rej_q;
  assign rd_valid   = (lvl_q != '0);
  assign fifo_level = lvl_q;
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      cnt_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      rej_q <= rd_start && !accept;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q   <= rd_len;
            lat_q   <= 4'(LAT - 1);
            state_q <= (LAT == 1) ? CAPT : WAIT;
          end
        end
        WAIT: begin
          lat_q <= lat_q - 4'd1;
          if (lat_q == 4'd1) state_q <= CAPT;
        end
        CAPT: begin
          cnt_q <= cnt_q - BL_W'(1);
          if (cnt_q == BL_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (pop && !push) lvl_q <= lvl_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= dataout;
  end

`ifdef RDCAP_LAST_TAG_EN
  logic last_q [DEPTH];
  logic last_w;

  assign last_w  = (cnt_q == BL_W'(1));
  assign rd_last = rd_valid && last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset && push) last_q[wr_ptr_q] <= last_w;
  end
`endif

endmodule

// File: tb/tb_sdram_rd_capture.sv
// tb_sdram_rd_capture: directed + random bursts against a queue/time-window model.
// Define RDCAP_LAST_TAG_EN on both files to also check rd_last.
module tb_sdram_rd_capture;

  localparam int LAT   = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic        last;
    logic [15:0] d;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        rd_start;
  logic [3:0]  rd_len;
  logic        rd_rej;
  logic        rd_busy;
  logic [15:0] dataout;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  fifo_level;
`ifdef RDCAP_LAST_TAG_EN
  logic        rd_last;
`endif

  sdram_rd_capture dut (
    .clk        (clk),
    .reset      (reset),
    .rd_start   (rd_start),
    .rd_len     (rd_len),
    .rd_rej     (rd_rej),
    .rd_busy    (rd_busy),
    .dataout    (dataout),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
`ifdef RDCAP_LAST_TAG_EN
    .rd_last    (rd_last),
`endif
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t q[$];
  int   cyc;
  int   b_lo;
  int   b_hi;
  int   c_lo;
  bit   rej_m;
  bit   dmode;
  int   n_chk;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_chk();
    bit busy_m;
    busy_m = (cyc >= b_lo) && (cyc < b_hi);
    chk("busy", 32'(rd_busy), 32'(busy_m));
    chk("rej", 32'(rd_rej), 32'(rej_m));
    chk("valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("level", 32'(fifo_level), 32'(q.size()));
    if (q.size() != 0) begin
      chk("data", 32'(rd_data), 32'(q[0].d));
`ifdef RDCAP_LAST_TAG_EN
      chk("last", 32'(rd_last), 32'(q[0].last));
    end else begin
      chk("last_idle", 32'(rd_last), 32'h0);
`endif
    end
  endtask

  // One clock: predict from the burst time window, then compare.
  task automatic step();
    bit busy, acc, psh, pp, lst;
    dataout = dmode ? 16'hA000 + 16'(cyc) : 16'($urandom);
    busy = (cyc >= b_lo) && (cyc < b_hi);
    psh  = (cyc >= c_lo) && (cyc < b_hi);
    lst  = psh && (cyc == b_hi - 1);
    pp   = (q.size() != 0) && rd_ready;
    acc  = rd_start && !busy && (rd_len != 0)
           && ((DEPTH - q.size()) >= int'(rd_len));
    rej_m = rd_start && !acc;
    if (pp) void'(q.pop_front());
    if (psh) q.push_back('{last: lst, d: dataout});
    if (acc) begin
      b_lo = cyc + 1;
      c_lo = cyc + LAT;
      b_hi = cyc + LAT + int'(rd_len);
    end
    @(posedge clk);
    #1;
    cyc++;
    rd_start = 1'b0;
    model_chk();
  endtask

  task automatic start(input int len);
    rd_start = 1'b1;
    rd_len   = 4'(len);
    step();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (cyc < b_hi && g < 64) begin
      step();
      g++;
    end
    chk("idle_timeout", 32'(cyc >= b_hi), 32'h1);
  endtask

  task automatic wait_lvl(input int n);
    int g;
    g = 0;
    while (q.size() < n && g < 64) begin
      step();
      g++;
    end
    chk("lvl_timeout", 32'(q.size() >= n), 32'h1);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    rd_start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    b_lo  = 0;
    b_hi  = 0;
    c_lo  = 0;
    rej_m = 1'b0;
    cyc   = 0;
    model_chk();
    chk("rst_data", 32'(rd_data), 32'h0);
  endtask

  task automatic single_burst();
    dmode    = 1'b1;
    rd_ready = 1'b1;
    while (cyc < 10) step();
    start(4);
    while (cyc < 19) begin
      step();
      if (cyc >= 15 && cyc <= 18) begin
        chk("sb_data", 32'(rd_data), 32'(16'hA000 + 16'(cyc - 1)));
        chk("sb_busy", 32'(rd_busy), 32'(cyc < 18));
      end
    end
    dmode = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    dmode    = 1'b0;
    rd_start = 1'b0;
    rd_len   = '0;
    rd_ready = 1'b0;
    dataout  = '0;
    do_reset();

    single_burst();

    // Fill to full under backpressure, then drain and refill.
    rd_ready = 1'b0;
    start(15);
    wait_idle();
    start(1);
    wait_idle();
    chk("full_lvl", 32'(fifo_level), 32'd16);
    start(1);
    chk("full_rej", 32'(rd_rej), 32'h1);
    rd_ready = 1'b1;
    repeat (16) step();
    chk("drained", 32'(rd_valid), 32'h0);
    rd_ready = 1'b0;
    start(8);
    wait_idle();
    rd_ready = 1'b1;
    repeat (8) step();

    // Rejects.
    rd_ready = 1'b0;
    start(0);
    chk("len0_rej", 32'(rd_rej), 32'h1);
    step();
    chk("len0_pulse", 32'(rd_rej), 32'h0);
    start(8);
    step();
    start(5);
    chk("busy_rej", 32'(rd_rej), 32'h1);
    wait_idle();
    start(4);
    wait_idle();
    chk("lvl12", 32'(fifo_level), 32'd12);
    start(5);
    chk("space_rej", 32'(rd_rej), 32'h1);
    chk("space_lvl", 32'(fifo_level), 32'd12);
    start(4);
    wait_idle();
    rd_ready = 1'b1;
    repeat (17) step();

    // Push and pop in the same cycle.
    rd_ready = 1'b0;
    start(8);
    wait_lvl(3);
    rd_ready = 1'b1;
    while (cyc < b_hi) begin
      step();
      chk("ovl_lvl", 32'(fifo_level), 32'd3);
    end
    repeat (4) step();

    // Reset in the middle of a burst.
    rd_ready = 1'b0;
    start(8);
    wait_lvl(2);
    do_reset();
    chk("mrst_valid", 32'(rd_valid), 32'h0);
    chk("mrst_lvl", 32'(fifo_level), 32'h0);
    chk("mrst_busy", 32'(rd_busy), 32'h0);
    single_burst();

    // Back-to-back bursts of 3 and 2.
    rd_ready = 1'b0;
    start(3);
    wait_idle();
    start(2);
    wait_idle();
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
`ifdef RDCAP_LAST_TAG_EN
      chk("tag", 32'(rd_last), 32'(i == 2 || i == 4));
`endif
      step();
    end

    // Random traffic.
    repeat (300) begin
      rd_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        rd_start = 1'b1;
        rd_len   = 4'($urandom_range(0, 15));
      end
      step();
    end
    rd_ready = 1'b1;
    repeat (40) step();
    chk("final_empty", 32'(rd_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_rd_capture.md
# sdram_rd_capture

- Read-data capture stage directly downstream of the SDRAM data path.
- Receives the data path's registered 16-bit read word (`dataout`) and a read-burst start strobe from the command sequencer.
- Counts out the fixed command-to-data latency, then captures exactly one burst of words into a show-ahead FIFO.
- Presents the captured words to the JPEG2000 consumer over a valid/ready handshake.
- Reserves FIFO space at command time, so an accepted burst can never overflow.

## Interface
- `DSIZE`, 16: data word width; matches the data path read width.
- `LAT`, 4: cycles from accepted `rd_start` to the first valid word on `dataout` (CAS latency plus data path registers); legal range 1..15.
- `DEPTH`, 16: FIFO depth in words; must be a power of 2, at least 2.
- `BL_W`, 4: width of the burst-length field.

Ports (`AW` = log2(`DEPTH`)):
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `rd_start` in 1: one-cycle request to capture a burst.
- `rd_len` in `BL_W`: burst length in words, sampled with `rd_start`; 0 is illegal and is rejected.
- `rd_rej` out 1: one-cycle pulse; `rd_start` was not accepted.
- `rd_busy` out 1: high while a burst is pending or being captured.
- `dataout` in `DSIZE`: registered read word from the data path.
- `rd_data` out `DSIZE`: FIFO head word.
- `rd_valid` out 1: FIFO non-empty.
- `rd_ready` in 1: consumer accepts the head word.
- `fifo_level` out `AW`+1: number of words stored (0..`DEPTH`).

## Operation
- State machine states: IDLE, WAIT, CAPT.
- IDLE:
  - `rd_start`=1 is accepted when `rd_len`≠0 and (`DEPTH` − `fifo_level`) ≥ `rd_len`.
  - On accept: latch `rd_len` into the word counter and load the latency counter with `LAT`−1.
  - Next state is WAIT, or CAPT directly when `LAT`=1.
  - Otherwise pulse `rd_rej` for one cycle and stay in IDLE.
- WAIT: decrement the latency counter; move to CAPT when it reaches 1.
- CAPT:
  - Each cycle push `dataout` and decrement the word counter.
  - After the push of the last word, go to IDLE.
- `rd_start` while `rd_busy`=1 is ignored and pulses `rd_rej`.
- Pops never reduce the space check below the reserved amount. Only the accepted burst writes, and space was reserved at accept.
- FIFO:
  - Show-ahead: `rd_data` = memory[rd_ptr], valid whenever `rd_valid`=1.
  - A pop happens when `rd_valid` & `rd_ready`.
  - Pointers are `AW` bits and wrap modulo `DEPTH`.
  - `fifo_level` +1 on a push only, −1 on a pop only, unchanged on a simultaneous push and pop.
  - A pop while empty is a no-op.
- The space check uses the current `fifo_level`, not counting a same-cycle pop.

## Timing
- `rd_start` accepted in cycle T:
  - `rd_busy`=1 from T+1.
  - `dataout` sampled in cycles T+`LAT` .. T+`LAT`+`rd_len`−1.
  - `rd_busy`=0 at T+`LAT`+`rd_len`; a new `rd_start` can be accepted in that cycle.
- A word pushed in cycle C is visible on `rd_data` with `rd_valid`=1 in cycle C+1.
- `rd_rej` is asserted in the cycle after the rejected `rd_start`.
- Reset values:
  - State IDLE; `rd_busy`=0, `rd_rej`=0.
  - `rd_valid`=0, `fifo_level`=0, `rd_data`=0.
  - Pointers and counters 0.
- Reset asserted mid-burst aborts the burst and discards all FIFO contents; no partial words survive.

## Configuration
- `RDCAP_LAST_TAG_EN`, when defined:
  - Adds output `rd_last` (1 bit), stored per FIFO entry and presented alongside `rd_data`.
  - `rd_last`=1 marks the final word of each burst; it resets to 0.
  - It is qualified by `rd_valid`.
- When undefined: no `rd_last` port and no tag storage. All other behaviour is identical.

## Test plan
- Single burst, default parameters:
  - Stimulus: `rd_start`, `rd_len`=4 at T=10; `dataout` = 0xA000+cycle; `rd_ready`=1.
  - Required: words 0xA00E..0xA011 appear on `rd_data` at T=15..18, in order.
  - Required: `rd_busy` falls at T=18.
- Backpressure and wrap:
  - Stimulus: `rd_ready`=0; bursts of 15 and then 1 word fill the FIFO to `fifo_level`=16.
  - Required: any further `rd_start` gives `rd_rej`=1.
  - Required: after draining 16 words, the output order is exact.
  - Required: a following burst of 8 words wraps the pointers correctly.
- Rejects:
  - Stimulus: `rd_len`=0; `rd_start` while busy; `rd_len`=5 with only 4 words free.
  - Required: each gives a single `rd_rej` pulse, with no state or level change.
- Simultaneous push and pop:
  - Stimulus: `fifo_level`=3, then capture continues with `rd_ready`=1.
  - Required: `fifo_level` holds at 3 during the overlap; no word is lost or duplicated.
- Reset mid-burst:
  - Stimulus: assert `reset`=0 during CAPT after 2 of 8 words.
  - Required: the next cycle shows `rd_valid`=0, `fifo_level`=0, `rd_busy`=0.
  - Required: a fresh burst after reset behaves as in the single-burst scenario.
- With `RDCAP_LAST_TAG_EN` defined:
  - Stimulus: back-to-back bursts of 3 and 2 words.
  - Required: `rd_last`=1 only on the 3rd and 5th popped words.
